pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake and a one-entry skid buffer. It is the successor to the fixed per-stage registers and sits between any two pipeline stages: fetch/decode, decode/execute, execute/memory, memory/writeback. It keeps the 2-bit hazard-unit control encoding: load, flush and hold. It adds three things:
- backpressure that does not propagate combinationally from `out_ready` to `in_ready`
- an occupancy report
- a saturating count of entries discarded by flushes

---
 rtl/pipe_stage_skid_if.sv | 26 ++
 rtl/pipe_stage_skid.sv | 105 ++++++++++
 tb/tb_pipe_stage_skid.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between a pipeline stage register and its neighbours:
// upstream/downstream valid-ready, hazard control and status.
interface pipe_stage_skid_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 8
);
    logic [1:0]       ctrl;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output ctrl, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, drop_cnt
    );

    modport slave (
        input  ctrl, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, drop_cnt
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a one-entry skid buffer, hazard-unit control
// (run/flush/hold) and a saturating count of entries discarded by flushes.
module pipe_stage_skid #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 8
) (
    input logic              clk,
    input logic              reset,
    pipe_stage_skid_if.slave bus
);

    // Bit 0 is main valid, bit 1 is skid valid; skid-only is unreachable.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [1:0]       occ;
    logic [CNT_W:0]   drop_sum;
    logic             run, flush, push, pop;

    assign run   = (bus.ctrl == 2'b00);
    assign flush = (bus.ctrl == 2'b01);

    // in_ready looks only at registered state and ctrl, never at out_ready.
    assign bus.in_ready  = run && (state_q != StFull);
    assign bus.out_valid = run && (state_q != StEmpty);
    assign bus.out_data  = main_q;
    assign bus.occupancy = occ;
    assign bus.drop_cnt  = drop_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        occ = 2'd0;
        case (state_q)
            StEmpty: occ = 2'd0;
            StOne:   occ = 2'd1;
            StFull:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    assign drop_sum = {1'b0, drop_q} + (CNT_W+1)'(occ);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        drop_d  = drop_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = '0;
            skid_d  = '0;
            drop_d  = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end else if (run) begin
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d = StOne;
                        main_d  = bus.in_data;
                    end
                end
                StOne: begin
                    if (push && !pop) begin
                        state_d = StFull;
                        skid_d  = bus.in_data;
                    end else if (push && pop) begin
                        main_d = bus.in_data;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic, checked
// against a queue-based model of the stage contents.
module tb_pipe_stage_skid;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_cmp;
    int   n_err;

    pipe_stage_skid_if #(.WIDTH(64), .CNT_W(8)) a_bus ();
    pipe_stage_skid_if #(.WIDTH(8), .CNT_W(2))  b_bus ();

    pipe_stage_skid #(.WIDTH(64), .CNT_W(8)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (a_bus.slave)
    );

    pipe_stage_skid #(.WIDTH(8), .CNT_W(2)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: FIFO of held entries, plus the value left in the output register
    // once it drains (cleared by flush and reset).
    logic [63:0] mq[$];
    logic [63:0] stale;
    int          drop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] c, input logic iv,
                        input logic [63:0] d, input logic ordy);
        logic        run, exp_ir, exp_ov, push, pop;
        logic [63:0] exp_od;
        @(negedge clk);
        rst_a           = r;
        a_bus.ctrl      = c;
        a_bus.in_valid  = iv;
        a_bus.in_data   = d;
        a_bus.out_ready = ordy;
        #1;
        run    = (c == 2'b00);
        exp_ir = run && (mq.size() < 2);
        exp_ov = run && (mq.size() != 0);
        exp_od = (mq.size() != 0) ? mq[0] : stale;
        check("in_ready", 64'(a_bus.in_ready), 64'(exp_ir));
        check("out_valid", 64'(a_bus.out_valid), 64'(exp_ov));
        check("out_data", a_bus.out_data, exp_od);
        check("occupancy", 64'(a_bus.occupancy), 64'(mq.size()));
        check("drop_cnt", 64'(a_bus.drop_cnt), 64'(drop));
        @(posedge clk);
        push = exp_ir && iv;
        pop  = exp_ov && ordy;
        if (!r) begin
            mq.delete();
            stale = '0;
            drop  = 0;
        end else if (c == 2'b01) begin
            drop = drop + mq.size();
            if (drop > 255) drop = 255;
            mq.delete();
            stale = '0;
        end else if (run) begin
            if (pop) stale = mq.pop_front();
            if (push) mq.push_back(d);
        end
    endtask

    task automatic bstep(input logic [1:0] c, input logic iv, input logic [7:0] d,
                         input logic ordy);
        @(negedge clk);
        b_bus.ctrl      = c;
        b_bus.in_valid  = iv;
        b_bus.in_data   = d;
        b_bus.out_ready = ordy;
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        drop  = 0;
        stale = '0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        a_bus.ctrl = 2'b00; a_bus.in_valid = 1'b0; a_bus.in_data = '0; a_bus.out_ready = 1'b1;
        b_bus.ctrl = 2'b00; b_bus.in_valid = 1'b0; b_bus.in_data = '0; b_bus.out_ready = 1'b1;
        @(posedge clk);

        // Reset then stream 1..4.
        step(1'b0, 2'b00, 1'b0, 64'h0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 64'h0, 1'b1);
        rst_b = 1'b1;
        step(1'b1, 2'b00, 1'b1, 64'h1, 1'b1);
        #2;
        check("stream_first", a_bus.out_data, 64'h1);
        step(1'b1, 2'b00, 1'b1, 64'h2, 1'b1);
        step(1'b1, 2'b00, 1'b1, 64'h3, 1'b1);
        step(1'b1, 2'b00, 1'b1, 64'h4, 1'b1);
        #2;
        check("stream_last", a_bus.out_data, 64'h4);
        check("stream_occ", 64'(a_bus.occupancy), 64'd1);
        step(1'b1, 2'b00, 1'b0, 64'h0, 1'b1);

        // Backpressure into skid.
        step(1'b1, 2'b00, 1'b1, 64'hA, 1'b0);
        step(1'b1, 2'b00, 1'b1, 64'hB, 1'b0);
        #2;
        check("bp_occ", 64'(a_bus.occupancy), 64'd2);
        check("bp_in_ready", 64'(a_bus.in_ready), 64'd0);
        check("bp_out_data", a_bus.out_data, 64'hA);
        step(1'b1, 2'b00, 1'b0, 64'h0, 1'b1);
        #2;
        check("bp_second", a_bus.out_data, 64'hB);
        step(1'b1, 2'b00, 1'b0, 64'h0, 1'b1);
        step(1'b1, 2'b00, 1'b0, 64'h0, 1'b1);

        // Build drop_cnt to 5, then flush a full buffer with a beat offered.
        step(1'b1, 2'b00, 1'b1, 64'h11, 1'b0);
        step(1'b1, 2'b00, 1'b1, 64'h12, 1'b0);
        step(1'b1, 2'b01, 1'b0, 64'h0, 1'b0);
        step(1'b1, 2'b00, 1'b1, 64'h13, 1'b0);
        step(1'b1, 2'b00, 1'b1, 64'h14, 1'b0);
        step(1'b1, 2'b01, 1'b0, 64'h0, 1'b0);
        step(1'b1, 2'b00, 1'b1, 64'h15, 1'b0);
        step(1'b1, 2'b01, 1'b0, 64'h0, 1'b0);
        step(1'b1, 2'b00, 1'b1, 64'h16, 1'b0);
        step(1'b1, 2'b00, 1'b1, 64'h17, 1'b0);
        #2;
        check("fl_pre_drop", 64'(a_bus.drop_cnt), 64'd5);
        step(1'b1, 2'b01, 1'b1, 64'hEE, 1'b1);
        #2;
        check("fl_occ", 64'(a_bus.occupancy), 64'd0);
        check("fl_out_data", a_bus.out_data, 64'h0);
        check("fl_drop", 64'(a_bus.drop_cnt), 64'd7);
        step(1'b1, 2'b00, 1'b0, 64'h0, 1'b1);

        // Hold freezes a ONE entry.
        step(1'b1, 2'b00, 1'b1, 64'h3C, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b1, 64'h55, 1'b1);
        #2;
        check("hold_occ", 64'(a_bus.occupancy), 64'd1);
        check("hold_data", a_bus.out_data, 64'h3C);
        step(1'b1, 2'b00, 1'b0, 64'h0, 1'b1);
        step(1'b1, 2'b00, 1'b0, 64'h0, 1'b1);

        // Reset during hold with a full buffer.
        step(1'b1, 2'b00, 1'b1, 64'h21, 1'b0);
        step(1'b1, 2'b00, 1'b1, 64'h22, 1'b0);
        step(1'b1, 2'b11, 1'b1, 64'h23, 1'b1);
        step(1'b0, 2'b11, 1'b1, 64'h24, 1'b1);
        #2;
        check("rh_occ", 64'(a_bus.occupancy), 64'd0);
        check("rh_drop", 64'(a_bus.drop_cnt), 64'd0);
        check("rh_out_data", a_bus.out_data, 64'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int unsigned sel;
            logic [1:0]  c;
            sel = $urandom_range(9, 0);
            c = (sel < 7) ? 2'b00 : (sel == 7) ? 2'b01 : (sel == 8) ? 2'b10 : 2'b11;
            step(($urandom_range(49, 0) != 0), c, 1'($urandom), {$urandom, $urandom},
                 1'($urandom));
        end

        // Saturation on the 2-bit counter instance.
        @(negedge clk);
        a_bus.ctrl = 2'b10;
        bstep(2'b00, 1'b1, 8'h11, 1'b0);
        bstep(2'b00, 1'b1, 8'h22, 1'b0);
        bstep(2'b01, 1'b0, 8'h00, 1'b0);
        check("sat_drop2", 64'(b_bus.drop_cnt), 64'd2);
        check("sat_occ", 64'(b_bus.occupancy), 64'd0);
        bstep(2'b00, 1'b1, 8'h33, 1'b0);
        bstep(2'b01, 1'b0, 8'h00, 1'b0);
        check("sat_drop3", 64'(b_bus.drop_cnt), 64'd3);
        bstep(2'b00, 1'b1, 8'h44, 1'b0);
        bstep(2'b01, 1'b0, 8'h00, 1'b0);
        check("sat_one", 64'(b_bus.drop_cnt), 64'd3);
        bstep(2'b00, 1'b1, 8'h55, 1'b0);
        bstep(2'b00, 1'b1, 8'h66, 1'b0);
        bstep(2'b01, 1'b0, 8'h00, 1'b0);
        check("sat_full", 64'(b_bus.drop_cnt), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
